// File: rtl/dat_mem_pkg.sv
// Shared types and default geometry for the parametrised data memory.
package dat_mem_pkg;

    typedef enum logic {CLEAR, READY} dm_state_t;

    localparam int unsigned DM_DW   = 8;
    localparam int unsigned DM_AW   = 8;
    localparam int unsigned DM_PCW  = 12;
    localparam int unsigned DM_CNTW = 16;

endpackage

// File: rtl/dm_wr_trace.sv
// Write-trace registers: PC and address of the last accepted write plus a
// saturating count of accepted writes.
module dm_wr_trace #(
    parameter int unsigned AW   = 8,
    parameter int unsigned PCW  = 12,
    parameter int unsigned CNTW = 16
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            wr_acc_i,
    input  logic [PCW-1:0]  pc_i,
    input  logic [AW-1:0]   addr_i,
    output logic [PCW-1:0]  last_pc_o,
    output logic [AW-1:0]   last_addr_o,
    output logic [CNTW-1:0] count_o
);

    logic [PCW-1:0]  pc_q;
    logic [AW-1:0]   addr_q;
    logic [CNTW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_acc_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q   <= '1;
            addr_q <= '0;
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (wr_acc_i) begin
                pc_q   <= pc_i;
                addr_q <= addr_i;
            end
        end
    end

    assign last_pc_o   = pc_q;
    assign last_addr_o = addr_q;
    assign count_o     = cnt_q;

endmodule

// File: rtl/dat_mem_param.sv
// Parametrised data memory: post-reset clear sweep, registered read with
// valid strobe, write-first bypass and write trace.
module dat_mem_param
    import dat_mem_pkg::*;
#(
    parameter int unsigned DW   = DM_DW,
    parameter int unsigned AW   = DM_AW,
    parameter int unsigned PCW  = DM_PCW,
    parameter int unsigned CNTW = DM_CNTW
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic            rd_en,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   dat_in,
    input  logic [PCW-1:0]  prog_ctr,
    output logic [DW-1:0]   dat_out,
    output logic            rd_valid,
    output logic            busy,
    output logic [PCW-1:0]  last_wr_pc,
    output logic [AW-1:0]   last_wr_addr,
    output logic [CNTW-1:0] wr_count
);

    dm_state_t       state_q;
    logic [AW-1:0]   clr_ptr_q;
    logic [DW-1:0]   dat_out_q;
    logic            rd_valid_q;
    logic            busy_q;
    logic [DW-1:0]   mem_q [(1 << AW)];
    logic            wr_acc;

    assign wr_acc = (state_q == READY) && wr_en;

    // Storage has no reset; the sweep is the only thing that clears it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem_q[clr_ptr_q] <= '0;
            end else if (wr_en) begin
                mem_q[addr] <= dat_in;
                $info("t=%0t write addr=0x%0h data=0x%0h", $time, addr, dat_in);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            dat_out_q  <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            rd_valid_q <= 1'b0;
            unique case (state_q)
                CLEAR: begin
                    clr_ptr_q <= clr_ptr_q + 1'b1;
                    if (clr_ptr_q == '1) begin
                        state_q <= READY;
                        busy_q  <= 1'b0;
                    end
                end
                READY: begin
                    if (rd_en) begin
                        rd_valid_q <= 1'b1;
                        // Shared address: a concurrent write always targets the read word.
                        dat_out_q  <= wr_en ? dat_in : mem_q[addr];
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end

    dm_wr_trace #(
        .AW   (AW),
        .PCW  (PCW),
        .CNTW (CNTW)
    ) u_trace (
        .clk_i       (clk),
        .reset_i     (reset),
        .wr_acc_i    (wr_acc),
        .pc_i        (prog_ctr),
        .addr_i      (addr),
        .last_pc_o   (last_wr_pc),
        .last_addr_o (last_wr_addr),
        .count_o     (wr_count)
    );

    assign dat_out  = dat_out_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_dat_mem_param.sv
// Bench for dat_mem_param: behavioural model compared every cycle against a
// default instance and a 4-bit-counter instance, plus literal spot checks.
module tb_dat_mem_param;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 8;
    localparam int unsigned PCW   = 12;
    localparam int unsigned DEPTH = 1 << AW;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           wr_en = 1'b0;
    logic           rd_en = 1'b0;
    logic [AW-1:0]  addr = '0;
    logic [DW-1:0]  dat_in = '0;
    logic [PCW-1:0] prog_ctr = '0;

    logic [DW-1:0]  dat_out, s_dat_out;
    logic           rd_valid, s_rd_valid;
    logic           busy, s_busy;
    logic [PCW-1:0] last_wr_pc, s_last_wr_pc;
    logic [AW-1:0]  last_wr_addr, s_last_wr_addr;
    logic [15:0]    wr_count;
    logic [3:0]     s_wr_count;

    int unsigned checks = 0;
    int unsigned errors = 0;

    dat_mem_param #(.DW(DW), .AW(AW), .PCW(PCW), .CNTW(16)) u_dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .dat_in(dat_in), .prog_ctr(prog_ctr), .dat_out(dat_out),
        .rd_valid(rd_valid), .busy(busy), .last_wr_pc(last_wr_pc),
        .last_wr_addr(last_wr_addr), .wr_count(wr_count)
    );

    dat_mem_param #(.DW(DW), .AW(AW), .PCW(PCW), .CNTW(4)) u_sat (
        .clk(clk), .reset(reset), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .dat_in(dat_in), .prog_ctr(prog_ctr), .dat_out(s_dat_out),
        .rd_valid(s_rd_valid), .busy(s_busy), .last_wr_pc(s_last_wr_pc),
        .last_wr_addr(s_last_wr_addr), .wr_count(s_wr_count)
    );

    always #5 clk = ~clk;

    // Reference model: a sweep is just "busy for DEPTH cycles, then all zero".
    bit             known = 1'b0;
    int             busy_cnt = 0;
    logic [DW-1:0]  mem_m [DEPTH];
    logic [DW-1:0]  dout_m = '0;
    logic           rv_m = 1'b0;
    logic [PCW-1:0] pc_m = '1;
    logic [AW-1:0]  addr_m = '0;
    int unsigned    wcnt_m = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic rd,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [PCW-1:0] pc);
        reset = r; wr_en = w; rd_en = rd; addr = a; dat_in = d; prog_ctr = pc;
        @(posedge clk);
        if (r) begin
            known = 1'b1; busy_cnt = DEPTH; rv_m = 1'b0; dout_m = '0;
            pc_m = '1; addr_m = '0; wcnt_m = 0;
        end else if (busy_cnt > 0) begin
            rv_m = 1'b0;
            busy_cnt--;
            if (busy_cnt == 0)
                for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        end else begin
            if (w) begin
                mem_m[a] = d; pc_m = pc; addr_m = a; wcnt_m++;
            end
            rv_m = rd;
            if (rd) dout_m = mem_m[a];
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    always @(negedge clk) begin
        if (known) begin
            chk("busy", 32'(busy), 32'(busy_cnt > 0));
            chk("rd_valid", 32'(rd_valid), 32'(rv_m));
            chk("dat_out", 32'(dat_out), 32'(dout_m));
            chk("last_wr_pc", 32'(last_wr_pc), 32'(pc_m));
            chk("last_wr_addr", 32'(last_wr_addr), 32'(addr_m));
            chk("wr_count", 32'(wr_count), (wcnt_m > 65535) ? 32'd65535 : wcnt_m);
            chk("sat_busy", 32'(s_busy), 32'(busy_cnt > 0));
            chk("sat_rd_valid", 32'(s_rd_valid), 32'(rv_m));
            chk("sat_dat_out", 32'(s_dat_out), 32'(dout_m));
            chk("sat_last_wr_pc", 32'(s_last_wr_pc), 32'(pc_m));
            chk("sat_last_wr_addr", 32'(s_last_wr_addr), 32'(addr_m));
            chk("sat_wr_count", 32'(s_wr_count), (wcnt_m > 15) ? 32'd15 : wcnt_m);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Sweep with busy gating probe at sweep cycles 10/11.
        step(1'b1, 1'b0, 1'b0, '0, '0, '0);
        chk("reset_busy", 32'(busy), 32'd1);
        chk("reset_last_wr_pc", 32'(last_wr_pc), 32'hFFF);
        chk("reset_wr_count", 32'(wr_count), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, i == 10, (i == 10) || (i == 11), 8'h05, 8'hFF, 12'h055);
            if (i == 11) begin
                chk("gated_rd_valid", 32'(rd_valid), 32'd0);
                chk("gated_wr_count", 32'(wr_count), 32'd0);
            end
            if (i == DEPTH - 2) chk("sweep_busy_last", 32'(busy), 32'd1);
            if (i == DEPTH - 1) chk("sweep_busy_done", 32'(busy), 32'd0);
        end

        step(1'b0, 1'b0, 1'b1, 8'h00, '0, '0);
        chk("clr_rd_00_valid", 32'(rd_valid), 32'd1);
        chk("clr_rd_00", 32'(dat_out), 32'h00);
        step(1'b0, 1'b0, 1'b1, 8'h7F, '0, '0);
        chk("clr_rd_7f", 32'(dat_out), 32'h00);
        step(1'b0, 1'b0, 1'b1, 8'hFF, '0, '0);
        chk("clr_rd_ff", 32'(dat_out), 32'h00);
        step(1'b0, 1'b0, 1'b1, 8'h05, '0, '0);
        chk("gated_rd_05", 32'(dat_out), 32'h00);

        step(1'b0, 1'b1, 1'b0, 8'h3C, 8'hA5, 12'h012);
        chk("wr_pc", 32'(last_wr_pc), 32'h012);
        chk("wr_addr", 32'(last_wr_addr), 32'h3C);
        chk("wr_count_1", 32'(wr_count), 32'd1);
        chk("wr_no_valid", 32'(rd_valid), 32'd0);
        step(1'b0, 1'b0, 1'b1, 8'h3C, '0, '0);
        chk("rd_3c_valid", 32'(rd_valid), 32'd1);
        chk("rd_3c", 32'(dat_out), 32'hA5);

        step(1'b0, 1'b1, 1'b1, 8'h10, 8'h5A, 12'h020);
        chk("bypass_dout", 32'(dat_out), 32'h5A);
        idle();
        chk("hold_valid", 32'(rd_valid), 32'd0);
        chk("hold_dout", 32'(dat_out), 32'h5A);
        step(1'b0, 1'b0, 1'b1, 8'h10, '0, '0);
        chk("bypass_mem", 32'(dat_out), 32'h5A);

        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
            step(1'b0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, a,
                 DW'($urandom), PCW'($urandom));
        end

        // Reset at sweep cycle 100 restarts the full sweep.
        step(1'b1, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 100; i++) idle();
        step(1'b1, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < DEPTH; i++) begin
            idle();
            if (i == DEPTH - 2) chk("resweep_busy_last", 32'(busy), 32'd1);
            if (i == DEPTH - 1) chk("resweep_busy_done", 32'(busy), 32'd0);
        end
        chk("resweep_pc", 32'(last_wr_pc), 32'hFFF);
        chk("resweep_count", 32'(wr_count), 32'd0);
        step(1'b0, 1'b0, 1'b1, 8'h3C, '0, '0);
        chk("resweep_rd_3c", 32'(dat_out), 32'h00);

        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b1, 1'b0, AW'(i), DW'(i + 1), PCW'(12'h100 + i));
        chk("sat_count", 32'(s_wr_count), 32'd15);
        chk("sat_pc", 32'(s_last_wr_pc), 32'h113);
        chk("full_count", 32'(wr_count), 32'd20);
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b0, 1'b1, AW'(i * 2), '0, '0);
        chk("b2b_valid", 32'(rd_valid), 32'd1);
        chk("b2b_dout", 32'(dat_out), 32'd15);

        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dat_mem_param.md
Name: dat_mem_param

Overview:
Parametrised successor to the processor's byte-wide data memory: generic data width, address width and program-counter width, with a clocked read port and read-valid strobe.
- Hardware clear sweep after reset.
- Write-first same-address bypass.
- Write-trace registers (last writer PC, last address, saturating write count) for debug and bench checking.
- Sits between the datapath load/store unit and the data store; the core must not issue accesses while busy is high.

Parameters:
DW, 8, data word width in bits
AW, 8, address width; depth = 2**AW words
PCW, 12, program-counter width carried into write trace
CNTW, 16, width of saturating write counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
wr_en  in  1  write request, sampled at posedge
rd_en  in  1  read request, sampled at posedge
addr  in  AW  shared read/write word address
dat_in  in  DW  write data
prog_ctr  in  PCW  PC of the issuing instruction, captured on accepted writes
dat_out  out  DW  registered read data
rd_valid  out  1  high exactly one cycle after an accepted read
busy  out  1  high while clear sweep is in progress; accesses ignored
last_wr_pc  out  PCW  prog_ctr of most recent accepted write
last_wr_addr  out  AW  addr of most recent accepted write
wr_count  out  CNTW  accepted-write count, saturates at all-ones

Behaviour:
- Reset is synchronous and active-high; clock is clk, reset is reset. Everything acts on posedge clk only.
- Reset values:
  - dat_out=0, rd_valid=0, busy=1.
  - last_wr_pc=all ones, last_wr_addr=0, wr_count=0.
  - Clear pointer=0, state=CLEAR.
- FSM has two states, CLEAR and READY.
  - CLEAR: each cycle writes 0 to core[clr_ptr], then clr_ptr++. When the write at clr_ptr=2**AW-1 completes, move to READY and drop busy on that same edge, so busy is high for exactly 2**AW cycles after reset deasserts.
  - READY: normal operation. There is no path back to CLEAR except reset.
- Reset asserted mid-sweep or in READY: sweep restarts at address 0 and trace registers are reinitialised. Memory contents are not otherwise touched by reset.
- Accesses while busy=1: wr_en and rd_en are ignored. No memory change, no trace update, rd_valid stays 0.
- Write (READY, wr_en=1), on the edge:
  - core[addr] <= dat_in.
  - last_wr_pc <= prog_ctr, last_wr_addr <= addr.
  - wr_count increments unless already all ones.
- Read (READY, rd_en=1): dat_out <= core[addr] on the edge and rd_valid=1 for the following cycle. Read latency is 1 cycle.
- No read: dat_out holds its previous value and rd_valid=0.
- Read and write in the same cycle, same address: write-first. dat_out takes dat_in and memory is updated.
- Read and write in the same cycle, different addresses: both proceed and dat_out takes the old contents of the read address. One shared address means this cannot happen in practice; it is documented for completeness.
- Back-to-back reads, one per cycle: rd_valid stays high continuously and dat_out changes every cycle.
- Address wrap: addr is exactly AW bits, so there is no out-of-range case. clr_ptr wraps to 0 only at sweep end, with the FSM already in READY.
- Simulation only: on each accepted write, $info reports the time, address and data.

Decomposition:
- Package dat_mem_pkg:
  - typedef enum logic {CLEAR, READY} dm_state_t;
  - localparam defaults for DW/AW/PCW/CNTW.
- One sub-module, dm_wr_trace: holds last_wr_pc, last_wr_addr and the saturating wr_count. Inputs are the accepted-write strobe, prog_ctr, addr and reset.
- Storage array, FSM and read register stay in the top module.

Test Plan:
- Reset sweep: reset 1 cycle with AW=8 → busy=1 for exactly 256 cycles then 0; reads of addr 0x00, 0x7F and 0xFF each return 0 with rd_valid=1 one cycle later.
- Write then read: write 0xA5 to 0x3C with prog_ctr=0x012 → last_wr_pc=0x012, last_wr_addr=0x3C, wr_count=1; next cycle rd_en at 0x3C → after 1 cycle dat_out=0xA5, rd_valid=1.
- Write-first bypass: wr_en=rd_en=1, addr=0x10, dat_in=0x5A, memory previously 0x00 → dat_out=0x5A next cycle and a later read returns 0x5A.
- Busy gating: during the sweep issue a write of 0xFF to 0x05 and a read of 0x05 → no rd_valid, wr_count stays 0; after the sweep, a read of 0x05 returns 0x00.
- Reset mid-sweep: assert reset at sweep cycle 100 → busy remains 1 for a full 256 cycles after the new reset; last_wr_pc=0xFFF.
- Counter saturation: CNTW=4, 20 writes in READY → wr_count stops at 15; last_wr_pc tracks the 20th write.
